uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8-bit/9600-baud receiver.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Adds input synchronisation, false-start rejection, parity/framing error flags and a valid/ack output handshake with overrun detection.
- Sits between the board rx pin and the downstream consumer (register file or FIFO).

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 9600, line rate; BIT_COUNTS = CLK_FREQ/BAUD (integer division, 5208 at defaults), HALF_COUNTS = BIT_COUNTS/2.
DATA_BITS, 8, payload width, legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  reset, asynchronous, active-low.
rx  input  1  asynchronous serial line, idle high.
rx_data  output  DATA_BITS  received payload, LSB received first.
data_valid  output  1  high while rx_data holds an unacknowledged frame.
data_ack  input  1  consumer acknowledge; clears data_valid.
parity_err  output  1  parity mismatch on the frame in rx_data (0 when PARITY_MODE = 0).
frame_err  output  1  a stop bit sampled 0 on the frame in rx_data.
overrun  output  1  sticky; a frame completed while data_valid = 1 with no ack.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0; synchroniser flops 1; FSM in IDLE; counters 0.
- Input path: rx passes through 2 flops (rx_s). Start detect is a 1→0 transition of rx_s, so a line held low (break) never retriggers.
- Baud counter: counts 0..BIT_COUNTS-1. It clears on start detect and on each state entry, and emits half_tick at HALF_COUNTS-1 and bit_tick at BIT_COUNTS-1.
- FSM states and transitions:
  - IDLE → START on falling edge of rx_s.
  - START, at half_tick: rx_s = 1 → IDLE (glitch rejected, nothing reported); rx_s = 0 → DATA, baud counter re-phased so subsequent ticks land mid-bit.
  - DATA: sample rx_s at each bit_tick into a shift register, LSB first. After DATA_BITS samples → PARITY if PARITY_MODE ≠ 0, else STOP.
  - PARITY: sample one bit. Even mode expects XOR(data, parity bit) = 0; odd mode expects it to be 1. Mismatch sets an internal perr.
  - STOP: sample STOP_BITS bits; any 0 sets an internal ferr. At the last stop sample → COMPLETE.
  - COMPLETE: 1 cycle, updates outputs, → IDLE.
- Output update in COMPLETE:
  - data_valid = 0, or data_ack = 1 in the same cycle: rx_data, parity_err and frame_err load the new frame; data_valid = 1.
  - data_valid = 1 and no ack: the new frame is discarded, old data is retained, overrun = 1.
- Handshake: data_ack while data_valid = 1 clears data_valid and overrun next cycle; rx_data and the error flags hold their values. data_ack while data_valid = 0 is ignored.
- Frames with frame_err are still delivered and flagged.
- Latency: data_valid rises 1 cycle after the mid-point of the final stop bit (3 clk of synchroniser/edge delay included in busy timing).
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge immediately after the stop bit is caught.
- Reset mid-frame: immediate return to reset state; the partial frame is lost; no flags.

Decomposition:
- Shared package uart_pkg: PARITY_NONE/EVEN/ODD constants, FSM state encoding (IDLE, START, DATA, PARITY, STOP, COMPLETE), helper function for the counter width ($clog2(BIT_COUNTS)).
- One sub-module uart_baud_tick: parametrised counter with clear and enable, producing half_tick/bit_tick. The receiver FSM, shift register and output registers stay in the top.

Test Plan:
Bench uses CLK_FREQ=1_000_000 and BAUD=100_000 (BIT_COUNTS = 10) unless noted.
- 8N1 frame 0xA5, then ack → rx_data = 0xA5, data_valid = 1 about 95 clk after the start edge, both errors 0; data_valid = 0 the cycle after ack.
- PARITY_MODE = 1, 8E1 frame 0x07 with parity bit 0 (correct value 1) → data_valid = 1, rx_data = 0x07, parity_err = 1; repeat with parity bit 1 → parity_err = 0. Also check PARITY_MODE = 2 for 0x07 (correct odd parity bit 0).
- rx low for 3 clk, then high → FSM returns to IDLE by half_tick, data_valid stays 0, busy drops.
- 8N1 frame 0x3C with stop bit 0 → rx_data = 0x3C, frame_err = 1; rx then held low for 50 clk → no further frame.
- Two frames 0x11 then 0x22 without ack → rx_data = 0x11, overrun = 1; ack → data_valid = 0, overrun = 0. Separately, ack coincident with COMPLETE → rx_data = 0x22, overrun = 0.
- n_rst asserted mid-DATA of frame 0xFF → all outputs 0 immediately; a following frame 0x5A is received correctly. Also run DATA_BITS = 7, STOP_BITS = 2 with frame 0x55 → rx_data = 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity mode codes,
// receiver FSM encoding and the baud counter width helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_COMPLETE = 3'd5
  } state_t;

  // Width of a counter that must hold 0..counts-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int counts);
    return (counts > 1) ? $clog2(counts) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate counter: counts 0..BIT_COUNTS-1 while enabled, clears on demand,
// and flags the half-bit and full-bit points of each bit period.
module uart_baud_tick #(
  parameter int BIT_COUNTS  = 10,
  parameter int HALF_COUNTS = 5,
  parameter int CW          = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic bit_tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Ticks decode the current count; they do not depend on clr, which itself
  // is derived from the FSM's reaction to these ticks.
  assign half_tick = en && (cnt_q == CW'(HALF_COUNTS - 1));
  assign bit_tick  = en && (cnt_q == CW'(BIT_COUNTS - 1));

  // Next count: clear has priority, otherwise wrap at the end of a bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (bit_tick) cnt_d = '0;
      else          cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, falling-edge start
// detect with false-start rejection, configurable data/parity/stop framing,
// and a valid/ack output handshake with sticky overrun.
module uart_rx_param #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int BIT_COUNTS  = CLK_FREQ / BAUD;
  localparam int HALF_COUNTS = BIT_COUNTS / 2;
  localparam int CW          = cnt_width(BIT_COUNTS);

  // Input path
  logic [1:0] sync_q;
  logic       rx_prev_q;
  logic       rx_s;
  logic       start_fall;

  // Receiver state
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;

  // Output registers
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;

  // Baud counter control
  logic cnt_clr;
  logic cnt_en;
  logic half_tick;
  logic bit_tick;

  assign rx_s       = sync_q[1];
  // A held-low line leaves rx_prev_q low too, so a break never retriggers.
  assign start_fall = rx_prev_q & ~rx_s;

  // Synchroniser and edge-detect history; idle-high after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  // The counter restarts on every state entry (including start detect), which
  // re-phases it at mid-start-bit so later bit_ticks fall mid-bit.
  assign cnt_en  = (state_q != ST_IDLE);
  assign cnt_clr = (state_d != state_q) || (state_q == ST_IDLE);

  uart_baud_tick #(
    .BIT_COUNTS  (BIT_COUNTS),
    .HALF_COUNTS (HALF_COUNTS),
    .CW          (CW)
  ) u_baud_tick (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  // Receiver FSM next-state, shift register and frame error tracking.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (start_fall) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (half_tick) begin
          // Line back high at mid-start-bit means it was only a glitch.
          if (rx_s) state_d = ST_IDLE;
          else      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          // Even: XOR of data and parity must be 0; odd: it must be 1.
          perr_d  = (^shift_q) ^ rx_s ^ (PARITY_MODE == PARITY_ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (!rx_s) ferr_d = 1'b1;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_COMPLETE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output handshake: deliver a finished frame unless an unacknowledged one
  // is still held, in which case the new frame is dropped and overrun set.
  always_comb begin
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    ovr_d     = ovr_q;
    if (data_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (state_q == ST_COMPLETE) begin
      if (!valid_q || data_ack) begin
        rx_data_d = shift_q;
        pe_d      = perr_q;
        fe_d      = ferr_q;
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Receiver and output state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign data_valid = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four configurations (8N1, 8E1, 8O1, 7N2)
// at 10 clocks per bit, sharing clock and reset, each with its own line.
module tb_uart_rx_param;

  logic       clk;
  logic       n_rst;
  logic       rx_line [0:3];
  logic       ack     [0:3];
  logic       dv      [0:3];
  logic       pe      [0:3];
  logic       fe      [0:3];
  logic       ov      [0:3];
  logic       bz      [0:3];
  logic [7:0] rd0, rd1, rd2;
  logic [6:0] rd3;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .n_rst(n_rst), .rx(rx_line[0]), .rx_data(rd0),
    .data_valid(dv[0]), .data_ack(ack[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));

  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY_MODE(1), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .n_rst(n_rst), .rx(rx_line[1]), .rx_data(rd1),
    .data_valid(dv[1]), .data_ack(ack[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));

  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1)) u_dut_8o1 (
    .clk(clk), .n_rst(n_rst), .rx(rx_line[2]), .rx_data(rd2),
    .data_valid(dv[2]), .data_ack(ack[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));

  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
                  .PARITY_MODE(0), .STOP_BITS(2)) u_dut_7n2 (
    .clk(clk), .n_rst(n_rst), .rx(rx_line[3]), .rx_data(rd3),
    .data_valid(dv[3]), .data_ack(ack[3]), .parity_err(pe[3]),
    .frame_err(fe[3]), .overrun(ov[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] get_data(input int idx);
    case (idx)
      0:       return {1'b0, rd0};
      1:       return {1'b0, rd1};
      2:       return {1'b0, rd2};
      default: return {2'b00, rd3};
    endcase
  endfunction

  // {data_valid, parity_err, frame_err, overrun, busy}
  function automatic logic [4:0] get_stat(input int idx);
    return {dv[idx], pe[idx], fe[idx], ov[idx], bz[idx]};
  endfunction

  // Drive n line bits (bits[0] first), 10 clocks each. ack is pulsed for one
  // cycle when the tick count equals ack_at. lat = tick at which data_valid
  // first rose (or -1), measured only if it started low.
  task automatic send_bits(input int idx, input logic [15:0] bits, input int n,
                           input int ack_at, output int lat);
    int   tick;
    logic dv_start;
    tick     = 0;
    lat      = -1;
    dv_start = dv[idx];
    for (int b = 0; b < n; b++) begin
      rx_line[idx] = bits[b];
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        tick++;
        #1;
        if (!dv_start && dv[idx] && lat < 0) lat = tick;
        ack[idx] = (tick == ack_at);
      end
    end
    $display("[TB] inst %0d sent %0d line bits 0x%0h, dv latency %0d", idx, n, bits, lat);
  endtask

  task automatic do_ack(input int idx);
    ack[idx] = 1'b1;
    @(posedge clk);
    #1;
    ack[idx] = 1'b0;
    $display("[TB] inst %0d ack", idx);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_line[i] = 1'b1;
      ack[i]     = 1'b0;
    end
    idle(3);
    check("reset_stat", 32'(get_stat(0)), 32'h0);
    check("reset_data", 32'(get_data(0)), 32'h0);
    n_rst = 1'b1;
    idle(5);

    // 8N1 0xA5
    send_bits(0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10, -1, lat);
    check("a5_latency_ok", 32'((lat >= 95) && (lat <= 100)), 32'h1);
    check("a5_data", 32'(get_data(0)), 32'hA5);
    check("a5_stat", 32'(get_stat(0)), 32'b10000);
    do_ack(0);
    check("a5_ack_dv", 32'(dv[0]), 32'h0);
    check("a5_hold_data", 32'(get_data(0)), 32'hA5);
    idle(5);

    // 8E1 0x07: parity bit 0 wrong, parity bit 1 right
    send_bits(1, {5'h0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, lat);
    check("e_bad_data", 32'(get_data(1)), 32'h07);
    check("e_bad_stat", 32'(get_stat(1)), 32'b11000);
    do_ack(1);
    idle(5);
    send_bits(1, {5'h0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, lat);
    check("e_good_stat", 32'(get_stat(1)), 32'b10000);
    do_ack(1);

    // 8O1 0x07: parity bit 0 right, parity bit 1 wrong
    send_bits(2, {5'h0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, lat);
    check("o_good_data", 32'(get_data(2)), 32'h07);
    check("o_good_stat", 32'(get_stat(2)), 32'b10000);
    do_ack(2);
    idle(5);
    send_bits(2, {5'h0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, lat);
    check("o_bad_stat", 32'(get_stat(2)), 32'b11000);
    do_ack(2);

    // Glitch: low 3 clocks then high
    rx_line[0] = 1'b0;
    idle(3);
    rx_line[0] = 1'b1;
    idle(2);
    check("glitch_busy", 32'(bz[0]), 32'h1);
    idle(7);
    check("glitch_stat", 32'(get_stat(0)), 32'b00000);
    idle(10);

    // 0x3C with stop bit 0, then line held low
    send_bits(0, {6'h0, 1'b0, 8'h3C, 1'b0}, 10, -1, lat);
    check("fe_data", 32'(get_data(0)), 32'h3C);
    check("fe_stat", 32'(get_stat(0)), 32'b10100);
    idle(50);
    check("break_stat", 32'(get_stat(0)), 32'b10100);
    do_ack(0);
    check("break_ack_dv", 32'(dv[0]), 32'h0);
    rx_line[0] = 1'b1;
    idle(20);

    // Overrun: 0x11 then 0x22 with no ack
    send_bits(0, {6'h0, 1'b1, 8'h11, 1'b0}, 10, -1, lat);
    send_bits(0, {6'h0, 1'b1, 8'h22, 1'b0}, 10, -1, lat);
    check("ovr_data", 32'(get_data(0)), 32'h11);
    check("ovr_stat", 32'(get_stat(0)), 32'b10010);
    do_ack(0);
    check("ovr_ack_stat", 32'(get_stat(0)), 32'b00000);
    idle(5);

    // Ack coincident with the completion cycle of the second frame
    send_bits(0, {6'h0, 1'b1, 8'h11, 1'b0}, 10, -1, lat);
    send_bits(0, {6'h0, 1'b1, 8'h22, 1'b0}, 10, 98, lat);
    check("coack_data", 32'(get_data(0)), 32'h22);
    check("coack_stat", 32'(get_stat(0)), 32'b10000);
    idle(5);

    // Reset mid-DATA of 0xFF (data_valid still set from 0x22)
    send_bits(0, {12'h0, 4'b1110}, 4, -1, lat);
    check("pre_rst_busy", 32'(bz[0]), 32'h1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_stat", 32'(get_stat(0)), 32'b00000);
    check("mid_rst_data", 32'(get_data(0)), 32'h0);
    rx_line[0] = 1'b1;
    idle(3);
    n_rst = 1'b1;
    idle(5);
    send_bits(0, {6'h0, 1'b1, 8'h5A, 1'b0}, 10, -1, lat);
    check("post_rst_data", 32'(get_data(0)), 32'h5A);
    check("post_rst_stat", 32'(get_stat(0)), 32'b10000);
    do_ack(0);

    // 7 data bits, 2 stop bits: 0x55 clean, then second stop bit low
    send_bits(3, {6'h0, 2'b11, 7'h55, 1'b0}, 10, -1, lat);
    check("7n2_data", 32'(get_data(3)), 32'h55);
    check("7n2_stat", 32'(get_stat(3)), 32'b10000);
    do_ack(3);
    idle(5);
    send_bits(3, {6'h0, 2'b01, 7'h2A, 1'b0}, 10, -1, lat);
    idle(3);
    check("7n2_fe_data", 32'(get_data(3)), 32'h2A);
    check("7n2_fe_stat", 32'(get_stat(3)), 32'b10100);
    rx_line[3] = 1'b1;
    do_ack(3);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
